// File: rtl/if_queue_pkg.sv
// Shared fetch-stage constants: NOP encoding and default XLEN / reset PC.
// Imported by the instruction queue, its interface and the pipeline top.
package if_queue_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_queue_if.sv
// Fetch-queue bus: instruction memory request/response, pipeline redirect
// and the decode-side head entry. The queue uses master, its environment slave.
interface if_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: imem transfer happens in a cycle with imem_req & imem_ready
  // (imem_rdata valid that same cycle); decode takes the head in a cycle with
  // id_valid & id_ready. Neither transfer happens in a cycle with redirect.
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic [CW-1:0]   count;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    input  redirect, redirect_pc,
    output id_valid,
    input  id_ready,
    output id_inst, id_pc, count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    output redirect, redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_inst, id_pc, count
  );

endinterface

// File: rtl/if_queue_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer with flush and an occupancy count.
// Pointers wrap naturally because DEPTH is a power of two.
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_queue.sv
// if_queue: instruction fetch controller feeding decode through ifq_fifo.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when empty.
module if_queue
  import if_queue_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input logic        clk,
  input logic        reset,
  if_queue_if.master bus
);
  localparam int              CW         = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]   fetch_pc;
  logic [2*XLEN-1:0] head_entry;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              accept;
  logic              bypass_take;
  logic              fifo_push;
  logic              fifo_pop;

  // A single-cycle handshake means at most one request is ever outstanding.
  assign bus.imem_req  = !reset && !fifo_full && !bus.redirect;
  assign bus.imem_addr = fetch_pc & ALIGN_MASK;
  assign accept        = bus.imem_req && bus.imem_ready;

`ifdef IFQ_BYPASS_EN
  assign bypass_take = accept && fifo_empty && bus.id_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign fifo_push = accept && !bypass_take;
  assign fifo_pop  = !reset && !fifo_empty && bus.id_ready && !bus.redirect;
  assign bus.count = fifo_count;

  always_ff @(posedge clk) begin
    if (reset)             fetch_pc <= RESET_PC;
    else if (bus.redirect) fetch_pc <= bus.redirect_pc & ALIGN_MASK;
    else if (accept)       fetch_pc <= fetch_pc + XLEN'(4);
  end

  always_comb begin
    bus.id_valid = 1'b0;
    bus.id_inst  = XLEN'(NOP_INST);
    bus.id_pc    = '0;
    if (!reset) begin
      if (!fifo_empty) begin
        bus.id_valid = 1'b1;
        bus.id_inst  = head_entry[XLEN-1:0];
        bus.id_pc    = head_entry[2*XLEN-1:XLEN];
      end
`ifdef IFQ_BYPASS_EN
      else if (accept) begin
        bus.id_valid = 1'b1;
        bus.id_inst  = bus.imem_rdata;
        bus.id_pc    = bus.imem_addr;
      end
`endif
    end
  end

  ifq_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (fifo_push),
    .push_data ({bus.imem_addr, bus.imem_rdata}),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: doc/if_queue.md
IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter XLEN, default 32, address/PC and instruction width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  XLEN  fetch address, word aligned.
REQ-008 imem_ready  input  1  memory accepted request and imem_rdata valid this cycle.
REQ-009 imem_rdata  input  XLEN  fetched instruction word.
REQ-010 redirect  input  1  branch/jump/flush from the pipeline.
REQ-011 redirect_pc  input  XLEN  new fetch target.
REQ-012 id_valid  output  1  head entry valid toward decode.
REQ-013 id_ready  input  1  decode consumes head (IF/ID write enable).
REQ-014 id_inst  output  XLEN  head instruction; NOP when id_valid=0.
REQ-015 id_pc  output  XLEN  PC of head instruction.
REQ-016 count  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-017 fetch_pc SHALL hold the next address; imem_addr = fetch_pc with bits[1:0] forced to 0.
REQ-018 imem_req SHALL be 1 when count < DEPTH and no redirect this cycle; at most one request outstanding.
REQ-019 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-020 Cycle with imem_req & imem_ready & !redirect: push {fetch_pc, imem_rdata}, fetch_pc += 4 (mod 2^XLEN, wrap allowed).
REQ-021 Pop SHALL occur when id_valid & id_ready & !redirect; head advances, count decrements.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including at count = DEPTH-1 and count = 1.
REQ-023 Full (count = DEPTH): imem_req = 0; a pop in that cycle re-enables imem_req next cycle.
REQ-024 Empty: id_valid = 0, id_inst = 32'h0000_0013, id_pc = 0; id_ready ignored.
REQ-025 redirect SHALL, next cycle: count = 0, read/write pointers reset, fetch_pc = redirect_pc & ~3.
REQ-026 A response with imem_ready in the redirect cycle SHALL be discarded.
REQ-027 redirect SHALL take priority over push, pop and full/empty state.
REQ-028 Latency without bypass: imem_ready accept to id_valid = 1 cycle.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.

Reset
REQ-030 On reset: fetch_pc = RESET_PC, count = 0, pointers = 0, imem_req = 0, id_valid = 0, id_inst = NOP, id_pc = 0.
REQ-031 imem_req SHALL first assert in the cycle after reset deasserts; reset overrides redirect.
REQ-032 Reset mid-request SHALL abandon the request; no stale response is pushed afterward.

Configuration
REQ-033 Macro IFQ_BYPASS_EN: when defined and queue empty, an accepted response SHALL appear on id_valid/id_inst/id_pc in the same cycle; if id_ready is also 1 it is consumed without entering the queue.
REQ-034 Without IFQ_BYPASS_EN: id_* outputs SHALL be driven from queue storage only (REQ-028).

Structure
REQ-035 Shared package SHALL hold NOP encoding 32'h0000_0013, RESET_PC default and XLEN default, also used by the pipeline top.
REQ-036 Storage SHALL be sub-module ifq_fifo (DEPTH x 2*XLEN, push/pop/flush, count); fetch control stays in if_queue.

Verification
REQ-037 Reset, imem_ready held 1, id_ready 0, DEPTH=4: addresses 0,4,8,12 issued, count = 4, imem_req = 0, id_pc = 0.
REQ-038 Full queue, id_ready pulsed 1 cycle: count 4->3, imem_req = 1 next cycle with addr 16; id_pc steps 0 -> 4.
REQ-039 imem_ready low 3 cycles at addr 8: imem_addr stays 8, no push; push on 4th cycle.
REQ-040 redirect with redirect_pc = 32'h0000_0102 while imem_ready = 1 and count = 2: response dropped, count = 0, next imem_addr = 32'h0000_0100.
REQ-041 fetch_pc = 32'hFFFF_FFFC accepted: next imem_addr = 0, entry id_pc = 32'hFFFF_FFFC.
REQ-042 IFQ_BYPASS_EN defined, empty, imem_ready & id_ready = 1: id_valid = 1 same cycle, count stays 0; undefined: id_valid next cycle.
